// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default sizes, the data word
// type, the memory read latency and the slot-index helper for the read stage.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int ADDR_W     = $clog2(FIFO_DEPTH);
    localparam int RD_LAT     = 1;

    typedef logic [FIFO_WIDTH-1:0] fifo_data_t;

    // Slot that is count entries past head in a 2-entry ring
    function automatic logic slot_idx(input logic head, input logic [1:0] count);
        return head ^ count[0];
    endfunction

endpackage

// File: rtl/fifo_rd_stream_chk.sv
// Invariant checks for the read stream stage: credit bound, no capture into a
// full buffer, no pop from an empty one, plus elaboration-time sanity checks.
module fifo_rd_stream_chk
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input logic       r_clk,
    input logic       rst_n,
    input logic [1:0] count,
    input logic       inflight,
    input logic       wr_en,
    input logic       pop
);

    // The credit scheme only covers a single cycle of memory latency
    if (RD_LAT != 1) begin : g_bad_lat
        $error("fifo_rd_stream supports only a one-cycle memory read latency");
    end
    if ((DEPTH < 2) || (ADDR_W < 1)) begin : g_bad_depth
        $error("fifo_rd_stream expects a FIFO depth of at least two");
    end

    a_credit_bound : assert property (@(posedge r_clk) disable iff (!rst_n)
        (({1'b0, count} + {2'b00, inflight}) <= 3'd2));

    a_no_capture_full : assert property (@(posedge r_clk) disable iff (!rst_n)
        !(wr_en && (count == 2'd2)));

    a_no_pop_empty : assert property (@(posedge r_clk) disable iff (!rst_n)
        !(pop && (count == 2'd0)));

endmodule

// File: rtl/fwft_buf2.sv
// Two-entry first-word-fall-through buffer. Its head word, valid flag and
// occupancy are all presented from registers.
module fwft_buf2
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             r_clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] buf0_r;
    logic [WIDTH-1:0] buf1_r;
    logic [WIDTH-1:0] buf0_nxt_s;
    logic [WIDTH-1:0] buf1_nxt_s;
    logic             head_r;
    logic             head_nxt_s;
    logic [1:0]       count_r;
    logic [1:0]       count_nxt_s;
    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_nxt_s;
    logic             wr_slot_s;

    // Next state: the word lands in the tail slot and head advances on pop
    always_comb begin
        buf0_nxt_s  = buf0_r;
        buf1_nxt_s  = buf1_r;
        wr_slot_s   = slot_idx(head_r, count_r);
        head_nxt_s  = head_r ^ pop;
        count_nxt_s = count_r + {1'b0, wr_en} - {1'b0, pop};
        if (wr_en && (wr_slot_s == 1'b0)) begin
            buf0_nxt_s = wr_data;
        end else begin
            buf0_nxt_s = buf0_r;
        end
        if (wr_en && (wr_slot_s == 1'b1)) begin
            buf1_nxt_s = wr_data;
        end else begin
            buf1_nxt_s = buf1_r;
        end
        // Head word is pre-selected so data leaves straight from a flop
        if (head_nxt_s) begin
            data_nxt_s = buf1_nxt_s;
        end else begin
            data_nxt_s = buf0_nxt_s;
        end
    end

    // Buffer storage, pointers and registered outputs
    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0_r  <= '0;
            buf1_r  <= '0;
            head_r  <= 1'b0;
            count_r <= 2'd0;
            valid_r <= 1'b0;
            data_r  <= '0;
        end else begin
            buf0_r  <= buf0_nxt_s;
            buf1_r  <= buf1_nxt_s;
            head_r  <= head_nxt_s;
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != 2'd0);
            data_r  <= data_nxt_s;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign count = count_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side output stage: turns the FIFO's request/empty interface with a
// one-cycle memory read into a first-word-fall-through valid/ready stream.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             r_clk,
    input  logic             rst_n,
    input  logic             empty,
    output logic             rd_rq,
    input  logic [WIDTH-1:0] rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       level
);

    logic       inflight_r;
    logic       pop_s;
    logic       accept_s;
    logic       rd_rq_s;
    logic [2:0] credit_s;
    logic       buf_valid_s;
    logic [1:0] buf_count_s;

    // Credit compare: a slot freed by this cycle's pop may be re-requested
    // at once, which is what keeps one word per cycle flowing
    always_comb begin
        pop_s    = buf_valid_s & m_ready;
        credit_s = {1'b0, buf_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        if (credit_s < 3'd2) begin
            rd_rq_s = 1'b1;
        end else begin
            rd_rq_s = 1'b0;
        end
        accept_s = rd_rq_s & ~empty;
    end

    // Tracks the read outstanding at the memory
    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= accept_s;
        end
    end

    fwft_buf2 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .r_clk   (r_clk),
        .rst_n   (rst_n),
        .wr_en   (inflight_r),
        .wr_data (rdata),
        .pop     (pop_s),
        .valid   (buf_valid_s),
        .data    (m_data),
        .count   (buf_count_s)
    );

    fifo_rd_stream_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .r_clk    (r_clk),
        .rst_n    (rst_n),
        .count    (buf_count_s),
        .inflight (inflight_r),
        .wr_en    (inflight_r),
        .pop      (pop_s)
    );

    assign rd_rq   = rd_rq_s;
    assign m_valid = buf_valid_s;
    assign level   = buf_count_s;

endmodule
